pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline (F/D/E/M/W).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 26 ++
 rtl/div_stall_counter.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
//============================================================================
// hazard_pkg : shared types and constants for the pipeline hazard controller
// Revision   : 1.0
//============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    MEM_WAIT = 2'd2,
    EXC      = 2'd3
  } hz_state_e;

  localparam int         DIV_CYCLES_DEFAULT = 32;
  localparam logic [4:0] REG_ZERO           = 5'd0;

  // Counter width able to hold DIV_CYCLES-1 (at least one bit).
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_stall_counter.sv
//============================================================================
// div_stall_counter : divide occupancy counter (load / decrement / freeze / clear)
// Revision          : 1.0
//============================================================================
`default_nettype none

module div_stall_counter
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  input  logic clear,
  output logic zero,
  output logic last
);

  localparam int CW = cnt_width(DIV_CYCLES);

  logic [CW-1:0] count;

  // Holding dec low freezes the count (used while memory stalls the pipe).
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(DIV_CYCLES - 1);
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  assign last = (count == CW'(1));

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
//============================================================================
// pipe_hazard_ctrl : stall/flush sequencer for the 5-stage F/D/E/M/W pipeline.
//                    Optional perf counters enabled by HAZ_PERF_CNT_EN.
// Revision         : 1.0
//============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_ready_F,
  input  logic       mem_req_M,
  input  logic       data_ready_M,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] rt_E,
  input  logic       memtoreg_E,
  input  logic       div_start_E,
  input  logic       mispred_E,
  input  logic       is_in_slot_D,
  input  logic       except_M,
  output logic       stall_F,
  output logic       stall_D,
  output logic       stall_E,
  output logic       stall_M,
  output logic       flush_D,
  output logic       flush_E,
  output logic       flush_M,
  output logic       flush_W,
  output logic       div_busy,
  output logic [1:0] state
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cyc
  , output logic [CNT_W-1:0] flush_cyc
`endif
);

  hz_state_e state_q, state_n;
  logic      div_pend, div_pend_n;
  logic      cnt_load, cnt_dec, cnt_clear, cnt_zero, cnt_last;
  logic      mem_stall, load_use;

  div_stall_counter #(.DIV_CYCLES(DIV_CYCLES)) u_div_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .clear (cnt_clear),
    .zero  (cnt_zero),
    .last  (cnt_last)
  );

  assign mem_stall = mem_req_M & ~data_ready_M;
  assign load_use  = memtoreg_E && (rt_E != REG_ZERO) && ((rt_E == rs_D) || (rt_E == rt_D));

  // div_pend spans launch through the completion cycle, so a divide paused by
  // MEM_WAIT resumes afterwards and the re-presented div_start_E is not relaunched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_pend <= 1'b0;
    end else begin
      state_q  <= state_n;
      div_pend <= div_pend_n;
    end
  end

  always_comb begin
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    stall_E    = 1'b0;
    stall_M    = 1'b0;
    flush_D    = 1'b0;
    flush_E    = 1'b0;
    flush_M    = 1'b0;
    flush_W    = 1'b0;
    state_n    = IDLE;
    div_pend_n = div_pend;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_clear  = 1'b0;
    if (rst) begin
      if (except_M) begin
        flush_D    = 1'b1;
        flush_E    = 1'b1;
        flush_M    = 1'b1;
        flush_W    = 1'b1;
        cnt_clear  = 1'b1;
        div_pend_n = 1'b0;
        state_n    = EXC;
      end else if (mem_stall) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
        state_n = MEM_WAIT;
      end else begin
        if (div_pend && !cnt_zero) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          stall_E = 1'b1;
          cnt_dec = 1'b1;
          state_n = cnt_last ? IDLE : DIV_BUSY;
        end else if (div_pend) begin
          div_pend_n = 1'b0;
        end else if (div_start_E) begin
          stall_F    = 1'b1;
          stall_D    = 1'b1;
          stall_E    = 1'b1;
          flush_M    = 1'b1;
          cnt_load   = 1'b1;
          div_pend_n = 1'b1;
          state_n    = (DIV_CYCLES > 1) ? DIV_BUSY : IDLE;
        end else if (load_use) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
        end else if (mispred_E && !is_in_slot_D) begin
          flush_D = 1'b1;
        end
        if (!instr_ready_F) begin
          stall_F = 1'b1;
          if (!stall_D) flush_D = 1'b1;
        end
      end
    end
  end

  assign div_busy = rst && (state_q == DIV_BUSY);
  assign state    = state_q;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cyc <= '0;
      flush_cyc <= '0;
    end else begin
      if (stall_D && stall_cyc != '1) stall_cyc <= stall_cyc + 1'b1;
      if (flush_D && flush_cyc != '1) flush_cyc <= flush_cyc + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//============================================================================
// tb_pipe_hazard_ctrl : scoreboard bench for pipe_hazard_ctrl (DIV_CYCLES=4)
// Revision            : 1.0
//============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, instr_ready_F, mem_req_M, data_ready_M;
  logic [4:0] rs_D, rt_D, rt_E;
  logic       memtoreg_E, div_start_E, mispred_E, is_in_slot_D, except_M;
  logic       stall_F, stall_D, stall_E, stall_M;
  logic       flush_D, flush_E, flush_M, flush_W, div_busy;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] exp_q[$];

  pipe_hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .instr_ready_F(instr_ready_F), .mem_req_M(mem_req_M),
    .data_ready_M(data_ready_M), .rs_D(rs_D), .rt_D(rt_D), .rt_E(rt_E),
    .memtoreg_E(memtoreg_E), .div_start_E(div_start_E), .mispred_E(mispred_E),
    .is_in_slot_D(is_in_slot_D), .except_M(except_M),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
    .div_busy(div_busy), .state(state)
  );

  always #5 clk = ~clk;

  // Observed vector: {sF,sD,sE,sM, fD,fE,fM,fW, busy, state[1:0]}
  wire [10:0] obs = {stall_F, stall_D, stall_E, stall_M,
                     flush_D, flush_E, flush_M, flush_W, div_busy, state};

  // Stimulus vector: {rst, ir_F, mreq_M, drdy_M, mtr_E, div_E, misp_E, slot_D, exc_M}
  task automatic apply(input logic [8:0] v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rte);
    {rst, instr_ready_F, mem_req_M, data_ready_M, memtoreg_E,
     div_start_E, mispred_E, is_in_slot_D, except_M} = v;
    rs_D = rs;
    rt_D = rt;
    rt_E = rte;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0]  stim [3];
    logic [10:0] expv [3];
    logic [10:0] e;
    stim = '{9'b0_0_1_0_1_1_1_0_1, 9'b0_0_1_0_0_1_0_0_1, 9'b1_1_0_0_0_0_0_0_0};
    expv = '{11'b0000_0000_0_00, 11'b0000_0000_0_00, 11'b0000_0000_0_00};
    for (int i = 0; i < 3; i++) begin
      apply(stim[i], 5'd1, 5'd1, 5'd1);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %b want %b", i, obs, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_load_use();
    logic [8:0]  stim [5];
    logic [4:0]  rsv  [5];
    logic [4:0]  rtv  [5];
    logic [4:0]  rtev [5];
    logic [10:0] expv [5];
    logic [10:0] e;
    stim = '{9'b1_1_0_0_1_0_0_0_0, 9'b1_1_0_0_0_0_0_0_0, 9'b1_1_0_0_1_0_0_0_0,
             9'b1_1_0_0_1_0_0_0_0, 9'b1_1_0_0_1_0_0_0_0};
    rsv  = '{5'd2, 5'd2, 5'd0, 5'd1, 5'd3};
    rtv  = '{5'd4, 5'd4, 5'd0, 5'd7, 5'd4};
    rtev = '{5'd2, 5'd2, 5'd0, 5'd7, 5'd2};
    expv = '{11'b1100_0100_0_00, 11'b0000_0000_0_00, 11'b0000_0000_0_00,
             11'b1100_0100_0_00, 11'b0000_0000_0_00};
    for (int i = 0; i < 5; i++) begin
      apply(stim[i], rsv[i], rtv[i], rtev[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %b want %b", i, obs, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_mispredict_fetch();
    logic [8:0]  stim [5];
    logic [10:0] expv [5];
    logic [10:0] e;
    stim = '{9'b1_1_0_0_0_0_1_1_0, 9'b1_1_0_0_0_0_1_0_0, 9'b1_0_0_0_0_0_0_0_0,
             9'b1_0_0_0_1_0_0_0_0, 9'b1_1_0_0_0_0_0_0_0};
    expv = '{11'b0000_0000_0_00, 11'b0000_1000_0_00, 11'b1000_1000_0_00,
             11'b1100_0100_0_00, 11'b0000_0000_0_00};
    for (int i = 0; i < 5; i++) begin
      apply(stim[i], 5'd6, 5'd6, 5'd6);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL mispredict_fetch[%0d]: got %b want %b", i, obs, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_divide();
    logic [8:0]  stim [6];
    logic [10:0] expv [6];
    logic [10:0] e;
    stim = '{9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0,
             9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_0_0_0_0};
    expv = '{11'b1110_0010_0_00, 11'b1110_0000_1_01, 11'b1110_0000_1_01,
             11'b1110_0000_1_01, 11'b0000_0000_0_00, 11'b0000_0000_0_00};
    for (int i = 0; i < 6; i++) begin
      apply(stim[i], 5'd0, 5'd0, 5'd0);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL divide[%0d]: got %b want %b", i, obs, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_mem_wait_in_div();
    logic [8:0]  stim [9];
    logic [10:0] expv [9];
    logic [10:0] e;
    stim = '{9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0, 9'b1_1_1_0_0_1_0_0_0,
             9'b1_1_1_0_0_1_0_0_0, 9'b1_1_1_0_0_1_0_0_0, 9'b1_1_1_1_0_1_0_0_0,
             9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_0_0_0_0};
    expv = '{11'b1110_0010_0_00, 11'b1110_0000_1_01, 11'b1111_0001_1_01,
             11'b1111_0001_0_10, 11'b1111_0001_0_10, 11'b1110_0000_0_10,
             11'b1110_0000_1_01, 11'b0000_0000_0_00, 11'b0000_0000_0_00};
    for (int i = 0; i < 9; i++) begin
      apply(stim[i], 5'd0, 5'd0, 5'd0);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL mem_wait_div[%0d]: got %b want %b", i, obs, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_exception();
    logic [8:0]  stim [12];
    logic [10:0] expv [12];
    logic [10:0] e;
    stim = '{9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_1,
             9'b1_1_0_0_0_0_0_0_1, 9'b1_1_0_0_0_0_0_0_0, 9'b1_1_0_0_0_0_0_0_0,
             9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0,
             9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_0_0_0_0};
    expv = '{11'b1110_0010_0_00, 11'b1110_0000_1_01, 11'b0000_1111_1_01,
             11'b0000_1111_0_11, 11'b0000_0000_0_11, 11'b0000_0000_0_00,
             11'b1110_0010_0_00, 11'b1110_0000_1_01, 11'b1110_0000_1_01,
             11'b1110_0000_1_01, 11'b0000_0000_0_00, 11'b0000_0000_0_00};
    for (int i = 0; i < 12; i++) begin
      apply(stim[i], 5'd0, 5'd0, 5'd0);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL exception[%0d]: got %b want %b", i, obs, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_div();
    logic [8:0]  stim [10];
    logic [10:0] expv [10];
    logic [10:0] e;
    stim = '{9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0, 9'b0_1_0_0_0_1_0_0_0,
             9'b1_1_0_0_0_0_0_0_0, 9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0,
             9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0, 9'b1_1_0_0_0_1_0_0_0,
             9'b1_1_0_0_0_0_0_0_0};
    expv = '{11'b1110_0010_0_00, 11'b1110_0000_1_01, 11'b0000_0000_0_01,
             11'b0000_0000_0_00, 11'b1110_0010_0_00, 11'b1110_0000_1_01,
             11'b1110_0000_1_01, 11'b1110_0000_1_01, 11'b0000_0000_0_00,
             11'b0000_0000_0_00};
    for (int i = 0; i < 10; i++) begin
      apply(stim[i], 5'd0, 5'd0, 5'd0);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_div[%0d]: got %b want %b", i, obs, e);
      end
      next_cycle();
    end
  endtask

  initial begin
    apply(9'b0_1_0_0_0_0_0_0_0, 5'd0, 5'd0, 5'd0);
    next_cycle();
    test_reset();
    test_load_use();
    test_mispredict_fetch();
    test_divide();
    test_mem_wait_in_div();
    test_exception();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
